// File: rtl/sdp_ram_block.sv
// Simple dual-port RAM: masked write port A, registered read port B (1-cycle latency).
// Define SDP_RAM_WR_BYPASS_EN for write-first same-address collisions; read-first otherwise.
module sdp_ram_block #(
   parameter int A_S = 8,
   parameter int M_S = 4,
   parameter int D_S = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wea,
   input  logic [M_S-1:0] bea,
   input  logic [A_S-1:0] addra,
   input  logic [D_S-1:0] dina,
   input  logic           reb,
   input  logic [A_S-1:0] addrb,
   output logic [D_S-1:0] doutb
);

   localparam int L_S     = D_S / M_S;
   localparam int DEPTH_S = 2 ** A_S;

   if ((D_S % M_S) != 32'd0) begin : g_lane_check
      $error("sdp_ram_block: D_S must be a multiple of M_S");
   end

   logic [D_S-1:0] data [0:DEPTH_S-1];
   logic [D_S-1:0] rd_word_s;
   logic [D_S-1:0] doutb_r;

   // Port A masked write; reset blocks writes but never clears contents.
   always_ff @(posedge clk) begin
      if (!rst && wea) begin
         for (int k = 0; k < M_S; k++) begin
            if (bea[k]) begin
               data[addra][k*L_S +: L_S] <= dina[k*L_S +: L_S];
            end
         end
      end
   end

`ifdef SDP_RAM_WR_BYPASS_EN
   // Read word with enabled write lanes forwarded on a same-address collision.
   always_comb begin
      rd_word_s = data[addrb];
      for (int k = 0; k < M_S; k++) begin
         if (wea && (addra == addrb) && bea[k]) begin
            rd_word_s[k*L_S +: L_S] = dina[k*L_S +: L_S];
         end else begin
            rd_word_s[k*L_S +: L_S] = data[addrb][k*L_S +: L_S];
         end
      end
   end
`else
   // Read word straight from storage, so collisions return the pre-write value.
   always_comb begin
      rd_word_s = data[addrb];
   end
`endif

   // Registered read data; an unknown strobe falls to the hold branch.
   always_ff @(posedge clk) begin
      if (rst) begin
         doutb_r <= {D_S{1'b0}};
      end else if (reb) begin
         doutb_r <= rd_word_s;
      end else begin
         doutb_r <= doutb_r;
      end
   end

   assign doutb = doutb_r;

endmodule

// File: tb/tb_sdp_ram_block.sv
// Randomised self-checking bench for sdp_ram_block against an array model.
module tb_sdp_ram_block;

   logic        clk = 1'b0;
   logic        rst;
   logic        wea;
   logic [3:0]  bea;
   logic [7:0]  addra;
   logic [31:0] dina;
   logic        reb;
   logic [7:0]  addrb;
   logic [31:0] doutb;

   logic [31:0] mem_m [0:255];
   logic [31:0] exp_dout;
   int          errors = 0;
   int          checks = 0;

   sdp_ram_block #(.A_S(8), .M_S(4), .D_S(32)) dut (
      .clk(clk), .rst(rst), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
      .reb(reb), .addrb(addrb), .doutb(doutb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] b);
      logic [31:0] m = 32'h0;
      for (int k = 0; k < 4; k++)
         if (b[k]) m = m | (32'hFF << (8 * k));
      return m;
   endfunction

   // Update the model for the coming edge, then step to just after it.
   task automatic cycle();
      logic [31:0] m;
      m = lane_mask(bea);
      if (rst) begin
         exp_dout = 32'h0;
      end else begin
         if (reb === 1'b1) begin
            exp_dout = mem_m[addrb];
`ifdef SDP_RAM_WR_BYPASS_EN
            if (wea && addra == addrb) exp_dout = (exp_dout & ~m) | (dina & m);
`endif
         end
         if (wea) mem_m[addra] = (mem_m[addra] & ~m) | (dina & m);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wea = 1'b0; bea = 4'h0; reb = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
      idle(); wea = 1'b1; bea = b; addra = a; dina = d;
      cycle();
   endtask

   task automatic rd(input logic [7:0] a);
      idle(); reb = 1'b1; addrb = a;
      cycle();
   endtask

   initial begin
      rst = 1'b1; idle(); addra = 8'h0; addrb = 8'h0; dina = 32'h0;
      for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
      cycle(); cycle();
      chk("reset_dout", doutb, 32'h0);
      rst = 1'b0;

      // Preload through port A.
      for (int i = 0; i < 256; i++) wr(i[7:0], 4'hF, 32'h4000_0000 + i);
      chk("preload_hold", doutb, 32'h0);

      // 1: basic read then hold.
      rd(8'h05);
      chk("read_05", doutb, 32'h4000_0005);
      idle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("hold_05", doutb, 32'h4000_0005);
      end

      // 2: masked write.
      wr(8'h10, 4'hF, 32'h1122_3344);
      wr(8'h10, 4'b0101, 32'hAABB_CCDD);
      rd(8'h10);
      chk("mask_write", doutb, 32'h11BB_33DD);
      wr(8'h11, 4'h0, 32'hFFFF_FFFF);
      rd(8'h11);
      chk("mask_zero_noop", doutb, 32'h4000_0011);

      // 3: same-address collision.
      wr(8'h03, 4'hF, 32'h0);
      idle(); wea = 1'b1; bea = 4'hF; addra = 8'h03; dina = 32'hDEAD_BEEF;
      reb = 1'b1; addrb = 8'h03;
      cycle();
`ifdef SDP_RAM_WR_BYPASS_EN
      chk("collision", doutb, 32'hDEAD_BEEF);
`else
      chk("collision", doutb, 32'h0);
`endif
      rd(8'h03);
      chk("collision_commit", doutb, 32'hDEAD_BEEF);

      // 4: address boundaries back-to-back.
      rd(8'hFF);
      chk("read_ff", doutb, 32'h4000_00FF);
      rd(8'h00);
      chk("read_00", doutb, 32'h4000_0000);

      // 5: reset mid-operation.
      rst = 1'b1; idle(); wea = 1'b1; bea = 4'hF; addra = 8'h20; dina = 32'h5555_AAAA;
      reb = 1'b1; addrb = 8'h20;
      cycle();
      chk("rst_dout_1", doutb, 32'h0);
      cycle();
      chk("rst_dout_2", doutb, 32'h0);
      rst = 1'b0;
      rd(8'h20);
      chk("rst_keeps_mem", doutb, 32'h4000_0020);
      rd(8'h05);
      chk("rst_keeps_mem_05", doutb, 32'h4000_0005);

      // Unknown strobe must behave as no read.
      idle(); reb = 1'bx; addrb = 8'h06;
      cycle();
      chk("x_strobe_hold", doutb, 32'h4000_0005);

      // 6: random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         wea   = 1'($urandom);
         bea   = 4'($urandom);
         addra = 8'($urandom);
         dina  = $urandom;
         reb   = 1'($urandom);
         addrb = ($urandom_range(0, 3) == 0) ? addra : 8'($urandom);
         cycle();
         chk("random", doutb, exp_dout);
      end

      // Sweep the whole array once more.
      for (int i = 0; i < 256; i++) begin
         rd(i[7:0]);
         chk("sweep", doutb, mem_m[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
